if_inst_responder: RTL and testbench
====================================

Name: if_inst_responder

Overview:
- Instruction-side responder that sits behind the IF stage: takes IF's `pc` and returns `if_inst`, `delay_hard` and the `{IADEE,IADFE}` exception pair.
- Translates the virtual PC and runs a request/address-ok/data-ok handshake to the instruction SRAM bus.
- Holds the last fetched word in a one-entry buffer.
- Absorbs flush/redirect while a bus transaction is outstanding.

Parameters:
- ADDR_MASK, 32'h1FFF_FFFF, physical mask applied to kseg0/kseg1 addresses.
- ALLOW_USEG, 1, when 1 kuseg (pc[31]=0) passes through untranslated; when 0 it raises IADFE.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- pc  in  32  fetch address from IF.
- pc_valid  in  1  IF requests the word at pc this cycle.
- flush  in  1  redirect/clean from IF; discard any in-flight or held word.
- inst_req  out  1  bus request.
- inst_addr  out  32  physical request address.
- inst_addr_ok  in  1  bus accepted the request.
- inst_rdata  in  32  bus read data.
- inst_data_ok  in  1  inst_rdata valid.
- if_inst  out  32  instruction returned to IF.
- delay_hard  out  1  word for pc not available; IF must hold.
- IADEE  out  1  address error: pc[1:0] != 0.
- IADFE  out  1  address fault: unmapped region.

Behaviour:
- Translation:
  - pc[31:30]=2'b10 (kseg0/1): phys = pc & ADDR_MASK.
  - pc[31]=0: phys = pc if ALLOW_USEG, else fault.
  - pc[31:30]=2'b11: fault.
- Exception priority: misaligned beats fault.
  - IADEE = pc_valid & (pc[1:0]!=0).
  - IADFE = pc_valid & !IADEE & unmapped.
  - On either: if_inst=0, delay_hard=0, no bus request.
- Buffer: held_valid, held_pc, held_inst.
  - Hit = pc_valid & held_valid & held_pc==pc & !flush.
  - On hit: if_inst=held_inst, delay_hard=0.
- FSM states: IDLE, ADDR, DATA, DISCARD.
  - IDLE: on a miss with pc_valid, no exception and no flush, drive inst_req=1 and inst_addr=phys(pc) combinationally, and latch req_pc=pc. If inst_addr_ok the same cycle go to DATA, else go to ADDR.
  - ADDR: inst_req=1 with inst_addr held at the latched value; the request is never withdrawn. On inst_addr_ok go to DATA, or to DISCARD if flush occurred this cycle or earlier while in ADDR (sticky flush_pend).
  - DATA: wait for inst_data_ok. When it arrives, write held_* = {1, req_pc, inst_rdata} and go to IDLE. A flush in this cycle drops the data and goes to IDLE with held_valid=0. A flush in DATA without data_ok goes to DISCARD.
  - DISCARD: on inst_data_ok drop the data and go to IDLE. The buffer is not written.
- Forwarding: in DATA with inst_data_ok & req_pc==pc & pc_valid & !flush, drive if_inst=inst_rdata and delay_hard=0 in that same cycle.
- delay_hard = pc_valid & !hit & !forward & !exception. It is 0 whenever pc_valid=0.
- Default if_inst=0 when there is no hit, no forward and no exception.
- Latency: miss issued in cycle N with addr_ok in N, data_ok in N+1, gives the word in N+1 via forward and from the buffer from N+2.
- Flush in IDLE clears held_valid. Flush has priority over hit and forward in the same cycle: delay_hard=0, if_inst=0.
- If pc changes while in DATA, the returning word is still written with req_pc. A new request starts only after returning to IDLE (one outstanding transaction max).
- inst_data_ok in IDLE or ADDR is ignored.
- Reset (async, any state):
  - state=IDLE, held_valid=0, flush_pend=0, req_pc=0.
  - Outputs: inst_req=0, inst_addr=0, if_inst=0, delay_hard=0, IADEE=0, IADFE=0.
  - A response belonging to a pre-reset transaction is ignored by the IDLE rule.

Test Plan:
- pc=32'hbfc0_0000, pc_valid=1, addr_ok immediate, data_ok next cycle with 32'h3c08_0001 -> inst_addr=32'h1fc0_0000; delay_hard 1 then 0 with if_inst=32'h3c08_0001; next cycle holds via buffer hit.
- addr_ok delayed 3 cycles -> inst_req held high with a stable inst_addr for 4 cycles; delay_hard=1 throughout; forward on data_ok.
- flush asserted in ADDR, then addr_ok, then data_ok=32'hdead_beef -> state passes through DISCARD; data is not forwarded or buffered; the next pc triggers a fresh request.
- pc=32'hbfc0_0002 -> IADEE=1, IADFE=0, inst_req=0, delay_hard=0, if_inst=0. pc=32'hc000_0000 -> IADFE=1. With ALLOW_USEG=0, pc=32'h0000_1000 -> IADFE=1.
- Reset asserted while in DATA, then data_ok pulsed after release -> all outputs 0, response ignored, held_valid=0, next miss re-requests.
- pc changes from 32'h8000_0000 to 32'h8000_0004 while in DATA -> no forward; buffer holds 32'h8000_0000; second request issued after IDLE.

Source files
------------

// File: rtl/if_inst_responder.sv
`default_nettype none
// ============================================================================
// Module   : if_inst_responder
// Purpose  : IF-side instruction responder. It translates the fetch PC,
//            runs the SRAM bus handshake and keeps a one-entry word buffer.
// Revision : 1.0 - initial release
// ============================================================================
module if_inst_responder #(
    parameter logic [31:0] ADDR_MASK  = 32'h1FFF_FFFF,
    parameter logic        ALLOW_USEG = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    input  logic        flush,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    output logic [31:0] if_inst,
    output logic        delay_hard,
    output logic        IADEE,
    output logic        IADFE
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ADDR    = 2'd1;
    localparam logic [1:0] c_DATA    = 2'd2;
    localparam logic [1:0] c_DISCARD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        held_valid_q, held_valid_d;
    logic [31:0] held_pc_q, held_pc_d;
    logic [31:0] held_inst_q, held_inst_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] addr_q, addr_d;
    logic        flush_pend_q, flush_pend_d;

    logic        w_misalign;
    logic        w_unmapped;
    logic        w_adee;
    logic        w_adfe;
    logic        w_exc;
    logic [31:0] w_phys;
    logic        w_hit;
    logic        w_fwd;
    logic        w_miss_req;

    assign w_misalign = (pc[1:0] != 2'b00);
    assign w_unmapped = (pc[31:30] == 2'b11) || (!pc[31] && !ALLOW_USEG);
    assign w_adee     = pc_valid && w_misalign;
    assign w_adfe     = pc_valid && !w_misalign && w_unmapped;
    assign w_exc      = w_adee || w_adfe;
    assign w_phys     = pc[31] ? (pc & ADDR_MASK) : pc;
    assign w_hit      = pc_valid && held_valid_q && (held_pc_q == pc) && !flush;
    assign w_fwd      = (state_q == c_DATA) && inst_data_ok && (req_pc_q == pc)
                        && pc_valid && !flush;
    assign w_miss_req = pc_valid && !w_exc && !flush && !w_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= c_IDLE;
            held_valid_q <= 1'b0;
            held_pc_q    <= 32'h0;
            held_inst_q  <= 32'h0;
            req_pc_q     <= 32'h0;
            addr_q       <= 32'h0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_valid_q <= held_valid_d;
            held_pc_q    <= held_pc_d;
            held_inst_q  <= held_inst_d;
            req_pc_q     <= req_pc_d;
            addr_q       <= addr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        held_valid_d = held_valid_q;
        held_pc_d    = held_pc_q;
        held_inst_d  = held_inst_q;
        req_pc_d     = req_pc_q;
        addr_d       = addr_q;
        flush_pend_d = flush_pend_q;
        if (flush) begin
            held_valid_d = 1'b0;
        end
        case (state_q)
            c_IDLE: begin
                flush_pend_d = 1'b0;
                if (w_miss_req) begin
                    req_pc_d = pc;
                    addr_d   = w_phys;
                    state_d  = inst_addr_ok ? c_DATA : c_ADDR;
                end
            end
            c_ADDR: begin
                // The request cannot be withdrawn, so a flush seen here only
                // marks the eventual response as one to throw away.
                if (inst_addr_ok) begin
                    state_d      = (flush_pend_q || flush) ? c_DISCARD : c_DATA;
                    flush_pend_d = 1'b0;
                end else begin
                    flush_pend_d = flush_pend_q || flush;
                end
            end
            c_DATA: begin
                if (inst_data_ok) begin
                    state_d = c_IDLE;
                    if (!flush) begin
                        held_valid_d = 1'b1;
                        held_pc_d    = req_pc_q;
                        held_inst_d  = inst_rdata;
                    end
                end else if (flush) begin
                    state_d = c_DISCARD;
                end
            end
            default: begin
                if (inst_data_ok) begin
                    state_d = c_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        inst_req   = 1'b0;
        inst_addr  = 32'h0;
        if_inst    = 32'h0;
        delay_hard = 1'b0;
        IADEE      = 1'b0;
        IADFE      = 1'b0;
        // Outputs are forced quiet for the whole time reset is held.
        if (!reset) begin
            IADEE = w_adee;
            IADFE = w_adfe;
            if (state_q == c_IDLE && w_miss_req) begin
                inst_req  = 1'b1;
                inst_addr = w_phys;
            end else if (state_q == c_ADDR) begin
                inst_req  = 1'b1;
                inst_addr = addr_q;
            end
            if (!w_exc) begin
                if (w_hit) begin
                    if_inst = held_inst_q;
                end else if (w_fwd) begin
                    if_inst = inst_rdata;
                end
            end
            delay_hard = pc_valid && !flush && !w_hit && !w_fwd && !w_exc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_inst_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_inst_responder
// Purpose  : Directed bench with an expected-response queue and a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_inst_responder;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [31:0] inst;
        logic        dh;
        logic        ee;
        logic        fe;
        logic        fe2;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic [31:0] if_inst;
    logic        delay_hard;
    logic        IADEE;
    logic        IADFE;

    logic        u_inst_req;
    logic [31:0] u_inst_addr;
    logic [31:0] u_if_inst;
    logic        u_delay_hard;
    logic        u_IADEE;
    logic        u_IADFE;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    if_inst_responder dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .flush(flush),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok), .if_inst(if_inst),
        .delay_hard(delay_hard), .IADEE(IADEE), .IADFE(IADFE)
    );

    // Second copy with kuseg disabled; only its fault output is observed.
    if_inst_responder #(.ALLOW_USEG(1'b0)) dut_nouseg (
        .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .flush(1'b0),
        .inst_req(u_inst_req), .inst_addr(u_inst_addr), .inst_addr_ok(1'b0),
        .inst_rdata(32'h0), .inst_data_ok(1'b0), .if_inst(u_if_inst),
        .delay_hard(u_delay_hard), .IADEE(u_IADEE), .IADFE(u_IADFE)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_fail++;
            $display("FAIL vec %0d %s: got %h expected %h", n_vec, name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            chk("inst_req",   {31'h0, inst_req},   {31'h0, e.req});
            chk("inst_addr",  inst_addr,           e.addr);
            chk("if_inst",    if_inst,             e.inst);
            chk("delay_hard", {31'h0, delay_hard}, {31'h0, e.dh});
            chk("IADEE",      {31'h0, IADEE},      {31'h0, e.ee});
            chk("IADFE",      {31'h0, IADFE},      {31'h0, e.fe});
            chk("IADFE_nouseg", {31'h0, u_IADFE},  {31'h0, e.fe2});
        end
    end

    // One cycle: drive inputs just after posedge, queue the expected response.
    task automatic step(
        input logic rst, input logic pv, input logic [31:0] p, input logic fl,
        input logic aok, input logic dok, input logic [31:0] rd,
        input logic x_req, input logic [31:0] x_addr, input logic [31:0] x_inst,
        input logic x_dh, input logic x_ee, input logic x_fe, input logic x_fe2);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        pc_valid     = pv;
        pc           = p;
        flush        = fl;
        inst_addr_ok = aok;
        inst_data_ok = dok;
        inst_rdata   = rd;
        e.req = x_req; e.addr = x_addr; e.inst = x_inst; e.dh = x_dh;
        e.ee = x_ee; e.fe = x_fe; e.fe2 = x_fe2;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; pc = 32'h0; pc_valid = 1'b0; flush = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        // rst pv pc fl aok dok rdata | req addr inst dh ee fe fe2
        step(1, 1, 32'hbfc0_0000, 0, 0, 0, 32'h0,           0, 32'h0,         32'h0,         0, 0, 0, 0);
        // Basic miss, forward, then buffer hit
        step(0, 1, 32'hbfc0_0000, 0, 1, 0, 32'h0,           1, 32'h1fc0_0000, 32'h0,         1, 0, 0, 0);
        step(0, 1, 32'hbfc0_0000, 0, 0, 1, 32'h3c08_0001,   0, 32'h0,         32'h3c08_0001, 0, 0, 0, 0);
        step(0, 1, 32'hbfc0_0000, 0, 0, 0, 32'h0,           0, 32'h0,         32'h3c08_0001, 0, 0, 0, 0);
        step(0, 0, 32'hbfc0_0000, 0, 0, 0, 32'h0,           0, 32'h0,         32'h0,         0, 0, 0, 0);
        // addr_ok three cycles late
        step(0, 1, 32'hbfc0_0004, 0, 0, 0, 32'h0,           1, 32'h1fc0_0004, 32'h0,         1, 0, 0, 0);
        step(0, 1, 32'hbfc0_0004, 0, 0, 0, 32'h0,           1, 32'h1fc0_0004, 32'h0,         1, 0, 0, 0);
        step(0, 1, 32'hbfc0_0004, 0, 0, 0, 32'h0,           1, 32'h1fc0_0004, 32'h0,         1, 0, 0, 0);
        step(0, 1, 32'hbfc0_0004, 0, 1, 0, 32'h0,           1, 32'h1fc0_0004, 32'h0,         1, 0, 0, 0);
        step(0, 1, 32'hbfc0_0004, 0, 0, 1, 32'h2409_0002,   0, 32'h0,         32'h2409_0002, 0, 0, 0, 0);
        step(0, 1, 32'hbfc0_0004, 0, 0, 0, 32'h0,           0, 32'h0,         32'h2409_0002, 0, 0, 0, 0);
        // Flush while in ADDR, response discarded, fresh request afterwards
        step(0, 1, 32'hbfc0_0008, 0, 0, 0, 32'h0,           1, 32'h1fc0_0008, 32'h0,         1, 0, 0, 0);
        step(0, 1, 32'hbfc0_0008, 1, 0, 0, 32'h0,           1, 32'h1fc0_0008, 32'h0,         0, 0, 0, 0);
        step(0, 1, 32'hbfc0_0008, 0, 1, 0, 32'h0,           1, 32'h1fc0_0008, 32'h0,         1, 0, 0, 0);
        step(0, 1, 32'hbfc0_0008, 0, 0, 1, 32'hdead_beef,   0, 32'h0,         32'h0,         1, 0, 0, 0);
        step(0, 1, 32'hbfc0_0008, 0, 1, 0, 32'h0,           1, 32'h1fc0_0008, 32'h0,         1, 0, 0, 0);
        step(0, 1, 32'hbfc0_0008, 0, 0, 1, 32'h1111_2222,   0, 32'h0,         32'h1111_2222, 0, 0, 0, 0);
        // Exceptions
        step(0, 1, 32'hbfc0_0002, 0, 0, 0, 32'h0,           0, 32'h0,         32'h0,         0, 1, 0, 0);
        step(0, 1, 32'hc000_0000, 0, 0, 0, 32'h0,           0, 32'h0,         32'h0,         0, 0, 1, 1);
        step(0, 1, 32'h0000_1000, 0, 1, 0, 32'h0,           1, 32'h0000_1000, 32'h0,         1, 0, 0, 1);
        step(0, 1, 32'h0000_1000, 0, 0, 1, 32'haaaa_5555,   0, 32'h0,         32'haaaa_5555, 0, 0, 0, 1);
        step(0, 1, 32'hc000_0003, 0, 0, 0, 32'h0,           0, 32'h0,         32'h0,         0, 1, 0, 0);
        // Reset while in DATA; late response ignored, request reissued
        step(0, 1, 32'h8000_0010, 0, 1, 0, 32'h0,           1, 32'h0000_0010, 32'h0,         1, 0, 0, 0);
        step(1, 1, 32'h8000_0010, 0, 0, 0, 32'h0,           0, 32'h0,         32'h0,         0, 0, 0, 0);
        step(0, 1, 32'h8000_0010, 0, 0, 1, 32'hffff_0000,   1, 32'h0000_0010, 32'h0,         1, 0, 0, 0);
        step(0, 1, 32'h8000_0010, 0, 1, 0, 32'h0,           1, 32'h0000_0010, 32'h0,         1, 0, 0, 0);
        step(0, 1, 32'h8000_0010, 0, 0, 1, 32'h0123_4567,   0, 32'h0,         32'h0123_4567, 0, 0, 0, 0);
        // PC moves while in DATA: word buffered under the old PC
        step(0, 1, 32'h8000_0000, 0, 1, 0, 32'h0,           1, 32'h0000_0000, 32'h0,         1, 0, 0, 0);
        step(0, 1, 32'h8000_0004, 0, 0, 1, 32'h0bad_f00d,   0, 32'h0,         32'h0,         1, 0, 0, 0);
        step(0, 1, 32'h8000_0004, 0, 0, 0, 32'h0,           1, 32'h0000_0004, 32'h0,         1, 0, 0, 0);
        step(0, 1, 32'h8000_0004, 0, 1, 0, 32'h0,           1, 32'h0000_0004, 32'h0,         1, 0, 0, 0);
        step(0, 1, 32'h8000_0000, 0, 0, 0, 32'h0,           0, 32'h0,         32'h0bad_f00d, 0, 0, 0, 0);
        step(0, 1, 32'h8000_0004, 0, 0, 1, 32'h1357_2468,   0, 32'h0,         32'h1357_2468, 0, 0, 0, 0);
        // Flush beats hit in IDLE and clears the buffer; flush drops DATA word
        step(0, 1, 32'h8000_0004, 1, 0, 0, 32'h0,           0, 32'h0,         32'h0,         0, 0, 0, 0);
        step(0, 1, 32'h8000_0004, 0, 0, 0, 32'h0,           1, 32'h0000_0004, 32'h0,         1, 0, 0, 0);
        step(0, 1, 32'h8000_0004, 0, 1, 0, 32'h0,           1, 32'h0000_0004, 32'h0,         1, 0, 0, 0);
        step(0, 1, 32'h8000_0004, 1, 0, 1, 32'h5555_aaaa,   0, 32'h0,         32'h0,         0, 0, 0, 0);
        step(0, 1, 32'h8000_0004, 0, 0, 0, 32'h0,           1, 32'h0000_0004, 32'h0,         1, 0, 0, 0);
        step(0, 0, 32'h8000_0004, 0, 0, 0, 32'h0,           1, 32'h0000_0004, 32'h0,         0, 0, 0, 0);
        @(posedge clk);
        #1;
        pc_valid = 1'b0;
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
